// File: rtl/reg_bank8_wr.sv
// ---------------------------------------------------------------------------
// reg_bank8_wr
//
// Purpose:
//   Eight-entry register bank fed by the one-hot output of a 3-to-8 select
//   decoder. Legal writes pass through a one-deep pending stage and commit
//   one edge after acceptance. Two registered read ports serve the datapath.
//   A non-one-hot select is dropped and sets a sticky error that blocks
//   further writes until it is cleared.
//
// Configuration:
//   WR_BYPASS_EN - when defined, a read port addressing the entry that the
//                  pending stage commits on the same edge returns the
//                  pending data (write-to-read forwarding, per port).
//                  When undefined, reads return the pre-commit contents.
//
// Parameters:
//   WIDTH        - data width of each entry and of the data ports
//
// Ports:
//   i_clk        - system clock, rising edge
//   i_rst_n      - asynchronous active-low reset
//   i_wr_valid   - write request valid
//   o_wr_ready   - bank accepts a write this cycle (= !o_sel_err)
//   i_wr_sel     - one-hot entry select from the decoder
//   i_wr_data    - write data
//   i_rd_addr_a  - read port A entry index
//   i_rd_addr_b  - read port B entry index
//   o_rd_data_a  - read port A data, one cycle after address
//   o_rd_data_b  - read port B data, one cycle after address
//   o_sel_err    - sticky illegal-select flag
//   i_err_clr    - clears o_sel_err
//   o_wr_count   - number of committed writes, wraps 255 -> 0
// ---------------------------------------------------------------------------
module reg_bank8_wr #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [7:0]       i_wr_sel,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [2:0]       i_rd_addr_a,
  input  logic [2:0]       i_rd_addr_b,
  output logic [WIDTH-1:0] o_rd_data_a,
  output logic [WIDTH-1:0] o_rd_data_b,
  output logic             o_sel_err,
  input  logic             i_err_clr,
  output logic [7:0]       o_wr_count
);

  logic [WIDTH-1:0] r_mem [8];

  logic             r_pendValid;
  logic [7:0]       r_pendSel;
  logic [WIDTH-1:0] r_pendData;

  logic             r_selErr;
  logic [7:0]       r_wrCount;
  logic [WIDTH-1:0] r_rdDataA;
  logic [WIDTH-1:0] r_rdDataB;

  logic             w_accept;
  logic             w_selLegal;

  assign o_wr_ready = ~r_selErr;
  assign w_accept   = i_wr_valid & o_wr_ready;

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
  assign w_selLegal = (i_wr_sel != 8'd0) &&
                      ((i_wr_sel & (i_wr_sel - 8'd1)) == 8'd0);

  // Pending stage: only a legal accept loads a valid write; anything else
  // (idle, stalled or illegal request) leaves the stage empty next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pendValid <= 1'b0;
      r_pendSel   <= 8'd0;
      r_pendData  <= '0;
    end else begin
      r_pendValid <= w_accept & w_selLegal;
      if (w_accept && w_selLegal) begin
        r_pendSel  <= i_wr_sel;
        r_pendData <= i_wr_data;
      end
    end
  end

  // Commit: the one-hot pending select is used directly as per-entry
  // write enables, so no re-encoding back to an index is needed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_pendValid) begin
      for (int i = 0; i < 8; i++) begin
        if (r_pendSel[i]) begin
          r_mem[i] <= r_pendData;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrCount <= 8'd0;
    end else if (r_pendValid) begin
      r_wrCount <= r_wrCount + 8'd1;
    end
  end

  // Sticky error: an illegal accept sets it and takes priority over a
  // simultaneous clear request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_selErr <= 1'b0;
    end else if (w_accept && !w_selLegal) begin
      r_selErr <= 1'b1;
    end else if (i_err_clr) begin
      r_selErr <= 1'b0;
    end
  end

`ifdef WR_BYPASS_EN
  logic w_fwdA;
  logic w_fwdB;

  // A port whose address hits the entry being committed this edge sees the
  // new data instead of the stale array contents.
  assign w_fwdA = r_pendValid & r_pendSel[i_rd_addr_a];
  assign w_fwdB = r_pendValid & r_pendSel[i_rd_addr_b];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdDataA <= '0;
      r_rdDataB <= '0;
    end else begin
      r_rdDataA <= w_fwdA ? r_pendData : r_mem[i_rd_addr_a];
      r_rdDataB <= w_fwdB ? r_pendData : r_mem[i_rd_addr_b];
    end
  end
`else
  // Reads sample the array before this edge's commit lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdDataA <= '0;
      r_rdDataB <= '0;
    end else begin
      r_rdDataA <= r_mem[i_rd_addr_a];
      r_rdDataB <= r_mem[i_rd_addr_b];
    end
  end
`endif

  assign o_rd_data_a = r_rdDataA;
  assign o_rd_data_b = r_rdDataB;
  assign o_sel_err   = r_selErr;
  assign o_wr_count  = r_wrCount;

endmodule

// File: tb/tb_reg_bank8_wr.sv
// ---------------------------------------------------------------------------
// tb_reg_bank8_wr
//
// Directed self-checking bench for reg_bank8_wr. Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point, so every check sees
// the state settled by the preceding edge. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_reg_bank8_wr;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic [2:0]       rd_addr_a;
  logic [2:0]       rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             sel_err;
  logic             err_clr;
  logic [7:0]       wr_count;

  int total;
  int bad;

  reg_bank8_wr #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_sel    (wr_sel),
    .i_wr_data   (wr_data),
    .i_rd_addr_a (rd_addr_a),
    .i_rd_addr_b (rd_addr_b),
    .o_rd_data_a (rd_data_a),
    .o_rd_data_b (rd_data_b),
    .o_sel_err   (sel_err),
    .i_err_clr   (err_clr),
    .o_wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_sel    = 8'd0;
    wr_data   = '0;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    err_clr   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_wr_ready got=%b want=1", wr_ready);
    end
    total++;
    if (sel_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_sel_err got=%b want=0", sel_err);
    end
    total++;
    if (wr_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_wr_count got=%0d want=0", wr_count);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      tick();
      total++;
      if (rd_data_a !== 8'h00) begin
        bad++;
        $display("[TB] FAIL reset_rd_a[%0d] got=%h want=00", i, rd_data_a);
      end
      total++;
      if (rd_data_b !== 8'h00) begin
        bad++;
        $display("[TB] FAIL reset_rd_b[%0d] got=%h want=00", 7 - i, rd_data_b);
      end
    end
  endtask

  task automatic test_single_write();
    wr_valid = 1'b1;
    wr_sel   = 8'b0000_0100;
    wr_data  = 8'hA5;
    tick();
    wr_valid = 1'b0;
    tick();
    total++;
    if (wr_count !== 8'd1) begin
      bad++;
      $display("[TB] FAIL single_wr_count got=%0d want=1", wr_count);
    end
    rd_addr_a = 3'd2;
    tick();
    total++;
    if (rd_data_a !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL single_entry2 got=%h want=a5", rd_data_a);
    end
    for (int i = 0; i < 8; i++) begin
      if (i != 2) begin
        rd_addr_b = 3'(i);
        tick();
        total++;
        if (rd_data_b !== 8'h00) begin
          bad++;
          $display("[TB] FAIL single_other[%0d] got=%h want=00", i, rd_data_b);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (wr_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_ready[%0d] got=%b want=1", i, wr_ready);
      end
      wr_valid = 1'b1;
      wr_sel   = 8'(1 << i);
      wr_data  = 8'h10 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    tick();
    total++;
    if (wr_count !== 8'd9) begin
      bad++;
      $display("[TB] FAIL b2b_wr_count got=%0d want=9", wr_count);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      tick();
      total++;
      if (rd_data_a !== 8'h10 + 8'(i)) begin
        bad++;
        $display("[TB] FAIL b2b_rd_a[%0d] got=%h want=%h", i, rd_data_a, 8'h10 + 8'(i));
      end
      total++;
      if (rd_data_b !== 8'h17 - 8'(i)) begin
        bad++;
        $display("[TB] FAIL b2b_rd_b[%0d] got=%h want=%h", 7 - i, rd_data_b, 8'h17 - 8'(i));
      end
    end
  endtask

  task automatic test_illegal_select();
    wr_valid = 1'b1;
    wr_sel   = 8'h03;
    wr_data  = 8'hFF;
    tick();
    total++;
    if (sel_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL illegal_sel_err got=%b want=1", sel_err);
    end
    total++;
    if (wr_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL illegal_wr_ready got=%b want=0", wr_ready);
    end
    // Legal write held while stalled must not be taken.
    wr_sel  = 8'h40;
    wr_data = 8'h77;
    tick();
    tick();
    total++;
    if (wr_count !== 8'd9) begin
      bad++;
      $display("[TB] FAIL illegal_wr_count got=%0d want=9", wr_count);
    end
    rd_addr_a = 3'd0;
    tick();
    total++;
    if (rd_data_a !== 8'h10) begin
      bad++;
      $display("[TB] FAIL illegal_entry0 got=%h want=10", rd_data_a);
    end
    rd_addr_a = 3'd1;
    tick();
    total++;
    if (rd_data_a !== 8'h11) begin
      bad++;
      $display("[TB] FAIL illegal_entry1 got=%h want=11", rd_data_a);
    end
    rd_addr_a = 3'd6;
    tick();
    total++;
    if (rd_data_a !== 8'h16) begin
      bad++;
      $display("[TB] FAIL stalled_entry6 got=%h want=16", rd_data_a);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++;
    if (sel_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clr_sel_err got=%b want=0", sel_err);
    end
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clr_wr_ready got=%b want=1", wr_ready);
    end
    tick();
    wr_valid = 1'b0;
    tick();
    total++;
    if (wr_count !== 8'd10) begin
      bad++;
      $display("[TB] FAIL held_wr_count got=%0d want=10", wr_count);
    end
    tick();
    total++;
    if (rd_data_a !== 8'h77) begin
      bad++;
      $display("[TB] FAIL held_entry6 got=%h want=77", rd_data_a);
    end
    // Zero-bit select together with a clear: the set takes priority.
    wr_valid = 1'b1;
    wr_sel   = 8'h00;
    err_clr  = 1'b1;
    tick();
    wr_valid = 1'b0;
    total++;
    if (sel_err !== 1'b1) begin
      bad++;
      $display("[TB] FAIL set_wins got=%b want=1", sel_err);
    end
    tick();
    err_clr = 1'b0;
    total++;
    if (sel_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL set_wins_clear got=%b want=0", sel_err);
    end
    total++;
    if (wr_count !== 8'd10) begin
      bad++;
      $display("[TB] FAIL zero_sel_count got=%0d want=10", wr_count);
    end
  endtask

  task automatic test_forwarding();
    logic [7:0] expFirst;
`ifdef WR_BYPASS_EN
    expFirst = 8'h3C;
`else
    expFirst = 8'h15;
`endif
    wr_valid = 1'b1;
    wr_sel   = 8'h20;
    wr_data  = 8'h3C;
    tick();
    wr_valid  = 1'b0;
    rd_addr_a = 3'd5;
    rd_addr_b = 3'd5;
    tick();
    total++;
    if (rd_data_a !== expFirst) begin
      bad++;
      $display("[TB] FAIL fwd_commit_a got=%h want=%h", rd_data_a, expFirst);
    end
    total++;
    if (rd_data_b !== expFirst) begin
      bad++;
      $display("[TB] FAIL fwd_commit_b got=%h want=%h", rd_data_b, expFirst);
    end
    tick();
    total++;
    if (rd_data_a !== 8'h3C) begin
      bad++;
      $display("[TB] FAIL fwd_after_a got=%h want=3c", rd_data_a);
    end
    total++;
    if (wr_count !== 8'd11) begin
      bad++;
      $display("[TB] FAIL fwd_wr_count got=%0d want=11", wr_count);
    end
  endtask

  task automatic test_wrap_and_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      wr_valid = 1'b1;
      wr_sel   = 8'(1 << (i % 8));
      wr_data  = 8'(i);
      tick();
      if (i == 255) begin
        total++;
        if (wr_count !== 8'd255) begin
          bad++;
          $display("[TB] FAIL wrap_pre got=%0d want=255", wr_count);
        end
      end
    end
    wr_valid = 1'b0;
    tick();
    total++;
    if (wr_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL wrap_count got=%0d want=0", wr_count);
    end
    // Reset with a write sitting in the pending stage.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wr_valid = 1'b1;
    wr_sel   = 8'h08;
    wr_data  = 8'hEE;
    tick();
    wr_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    rd_addr_a = 3'd3;
    tick();
    tick();
    total++;
    if (rd_data_a !== 8'h00) begin
      bad++;
      $display("[TB] FAIL rst_pending_entry3 got=%h want=00", rd_data_a);
    end
    total++;
    if (wr_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL rst_pending_count got=%0d want=0", wr_count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_illegal_select();
    test_forwarding();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
